// File: rtl/param_if_stage.sv
// Parametrised instruction-fetch stage: PC, branch redirect with one-entry stall buffer,
// internal instruction memory and IF/ID register. Optional counters under IF_PERF_CNT_EN.
module param_if_stage #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 7,
  parameter int                 PC_INC   = 1,
  parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              ex_mem_pcrsrc,
  input  logic [DATA_W-1:0] ex_mem_npc,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [DATA_W-1:0] imem_wdata,
  output logic [DATA_W-1:0] pc,
  output logic              redirect_pending,
  output logic [DATA_W-1:0] IF_ID_npc,
  output logic [DATA_W-1:0] IF_ID_instr,
  output logic              IF_ID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef enum logic {RUN, PENDING} state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] pc_reg, pc_next;
  logic [DATA_W-1:0] target_reg, target_next;
  logic [DATA_W-1:0] npc_reg, npc_next;
  logic [DATA_W-1:0] instr_reg, instr_next;
  logic              valid_reg, valid_next;
  logic              fetch_evt, bubble_evt;

  logic [DATA_W-1:0] imem_reg [2**ADDR_W];
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] seq;

  // Combinational read; a same-cycle write is only seen from the next cycle.
  assign instr = imem_reg[pc_reg[ADDR_W-1:0]];
  assign seq   = pc_reg + DATA_W'(PC_INC);

  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_reg[imem_waddr] <= imem_wdata;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    target_next = target_reg;
    npc_next    = npc_reg;
    instr_next  = instr_reg;
    valid_next  = valid_reg;
    fetch_evt   = 1'b0;
    bubble_evt  = 1'b0;
    case (state_reg)
      PENDING: begin
        // A buffered redirect wins over any new branch strobe.
        if (!stall) begin
          pc_next     = target_reg;
          target_next = '0;
          npc_next    = '0;
          instr_next  = '0;
          valid_next  = 1'b0;
          bubble_evt  = 1'b1;
          state_next  = RUN;
        end
      end
      default: begin
        if (ex_mem_pcrsrc && !stall) begin
          pc_next    = ex_mem_npc;
          npc_next   = '0;
          instr_next = '0;
          valid_next = 1'b0;
          bubble_evt = 1'b1;
        end else if (ex_mem_pcrsrc) begin
          target_next = ex_mem_npc;
          state_next  = PENDING;
        end else if (!stall) begin
          pc_next    = seq;
          npc_next   = seq;
          instr_next = instr;
          valid_next = 1'b1;
          fetch_evt  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= RUN;
      pc_reg     <= RESET_PC;
      target_reg <= '0;
      npc_reg    <= '0;
      instr_reg  <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      target_reg <= target_next;
      npc_reg    <= npc_next;
      instr_reg  <= instr_next;
      valid_reg  <= valid_next;
    end
  end

  assign pc               = pc_reg;
  assign redirect_pending = (state_reg == PENDING);
  assign IF_ID_npc        = npc_reg;
  assign IF_ID_instr      = instr_reg;
  assign IF_ID_valid      = valid_reg;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg, bubble_cnt_reg;

  // Both counters saturate instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (fetch_evt && (fetch_cnt_reg != 32'hFFFF_FFFF)) begin
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      end
      if (bubble_evt && (bubble_cnt_reg != 32'hFFFF_FFFF)) begin
        bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`else
  logic unused_evt;
  assign unused_evt = fetch_evt ^ bubble_evt;
`endif

endmodule

// File: tb/tb_param_if_stage.sv
// Self-checking bench for param_if_stage: vector table for the main fetch/redirect
// sequence plus hand-written memory-write and mid-run reset sequences.
module tb_param_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        ex_mem_pcrsrc = 1'b0;
  logic [31:0] ex_mem_npc = '0;
  logic        imem_we = 1'b0;
  logic [6:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [31:0] pc;
  logic        redirect_pending;
  logic [31:0] IF_ID_npc;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  param_if_stage #(.DATA_W(32), .ADDR_W(7), .PC_INC(1), .RESET_PC(32'd0)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .ex_mem_pcrsrc(ex_mem_pcrsrc), .ex_mem_npc(ex_mem_npc),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .pc(pc), .redirect_pending(redirect_pending),
    .IF_ID_npc(IF_ID_npc), .IF_ID_instr(IF_ID_instr), .IF_ID_valid(IF_ID_valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          stall;
    bit          pcrsrc;
    logic [31:0] npc;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_npc;
    bit          e_valid;
    bit          e_pend;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_npc, input bit e_valid, input bit e_pend);
    chk({tag, " pc"}, pc, e_pc);
    chk({tag, " instr"}, IF_ID_instr, e_instr);
    chk({tag, " npc"}, IF_ID_npc, e_npc);
    chk({tag, " valid"}, {31'd0, IF_ID_valid}, {31'd0, e_valid});
    chk({tag, " pending"}, {31'd0, redirect_pending}, {31'd0, e_pend});
    $display("%s: pc=%h instr=%h npc=%h valid=%0b pend=%0b", tag, pc, IF_ID_instr, IF_ID_npc,
             IF_ID_valid, redirect_pending);
  endtask

  // Drive inputs on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input bit s, input bit br, input logic [31:0] tgt,
                      input bit we, input logic [6:0] wa, input logic [31:0] wd);
    @(negedge clk);
    stall = s; ex_mem_pcrsrc = br; ex_mem_npc = tgt;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          stall br  target         pc             instr   npc            valid pend
    vecs[0]  = '{0, 0, 32'd0,          32'd1,         32'd100, 32'd1,         1, 0};
    vecs[1]  = '{0, 0, 32'd0,          32'd2,         32'd101, 32'd2,         1, 0};
    vecs[2]  = '{0, 0, 32'd0,          32'd3,         32'd102, 32'd3,         1, 0};
    vecs[3]  = '{0, 0, 32'd0,          32'd4,         32'd103, 32'd4,         1, 0};
    vecs[4]  = '{0, 0, 32'd0,          32'd5,         32'd104, 32'd5,         1, 0};
    vecs[5]  = '{0, 1, 32'd20,         32'd20,        32'd0,   32'd0,         0, 0};
    vecs[6]  = '{0, 0, 32'd0,          32'd21,        32'd120, 32'd21,        1, 0};
    vecs[7]  = '{1, 1, 32'd40,         32'd21,        32'd120, 32'd21,        1, 1};
    vecs[8]  = '{1, 1, 32'd60,         32'd21,        32'd120, 32'd21,        1, 1};
    vecs[9]  = '{1, 0, 32'd0,          32'd21,        32'd120, 32'd21,        1, 1};
    vecs[10] = '{0, 1, 32'd60,         32'd40,        32'd0,   32'd0,         0, 0};
    vecs[11] = '{0, 0, 32'd0,          32'd41,        32'd140, 32'd41,        1, 0};
    vecs[12] = '{1, 0, 32'd0,          32'd41,        32'd140, 32'd41,        1, 0};
    vecs[13] = '{0, 1, 32'd127,        32'd127,       32'd0,   32'd0,         0, 0};
    vecs[14] = '{0, 0, 32'd0,          32'd128,       32'd227, 32'd128,       1, 0};
    vecs[15] = '{0, 0, 32'd0,          32'd129,       32'd100, 32'd129,       1, 0};
    vecs[16] = '{0, 1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,   32'd0,         0, 0};
    vecs[17] = '{0, 0, 32'd0,          32'd0,         32'd227, 32'd0,         1, 0};
    vecs[18] = '{0, 0, 32'd0,          32'd1,         32'd100, 32'd1,         1, 0};

    // Load imem[i] = i + 100 while reset holds the pipeline.
    for (int i = 0; i < 128; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b1, 7'(i), 32'(i + 100));
    end
    check_state("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("reset fetch_cnt", fetch_cnt, 32'd0);
    chk("reset bubble_cnt", bubble_cnt, 32'd0);
`endif

    @(negedge clk);
    imem_we = 1'b0; stall = 1'b1; reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].stall, vecs[i].pcrsrc, vecs[i].npc, 1'b0, 7'd0, 32'd0);
      check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_npc,
                  vecs[i].e_valid, vecs[i].e_pend);
    end
`ifdef IF_PERF_CNT_EN
    chk("perf fetch_cnt", fetch_cnt, 32'd11);
    chk("perf bubble_cnt", bubble_cnt, 32'd4);
`endif

    // Same-cycle write to the word being fetched returns the old word.
    step(1'b0, 1'b1, 32'd3, 1'b0, 7'd0, 32'd0);
    check_state("wr branch3", 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 7'd3, 32'h0000_ABCD);
    check_state("wr same", 32'd4, 32'd103, 32'd4, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'd3, 1'b0, 7'd0, 32'd0);
    check_state("wr back3", 32'd3, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 7'd0, 32'd0);
    check_state("wr new", 32'd4, 32'h0000_ABCD, 32'd4, 1'b1, 1'b0);

    // Asynchronous reset with a redirect pending discards it at once.
    step(1'b1, 1'b1, 32'd50, 1'b0, 7'd0, 32'd0);
    check_state("pre-rst", 32'd4, 32'h0000_ABCD, 32'd4, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_state("async rst", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("rst fetch_cnt", fetch_cnt, 32'd0);
    chk("rst bubble_cnt", bubble_cnt, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; ex_mem_pcrsrc = 1'b0;
    @(posedge clk);
    #1;
    check_state("post-rst", 32'd1, 32'd100, 32'd1, 1'b1, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("post fetch_cnt", fetch_cnt, 32'd1);
    chk("post bubble_cnt", bubble_cnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
